// File: rtl/interrupt_ack_sequencer.sv
// Priority resolution, two-pulse INTA acknowledge sequencing and OCW2 EOI/rotation
// decode for an 8259A-style interrupt controller.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for the first INTA falling edge; int_out may assert
// WAIT_ACK2 | winner (or spurious level) held; waiting for second INTA
module interrupt_ack_sequencer #(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request,
    input  logic [7:0] interrupt_mask,
    input  logic [7:0] isr,
    input  logic       inta_n,
    input  logic       ocw2_write,
    input  logic [7:0] ocw2_data,
    input  logic       auto_eoi,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic       latch_isr,
    output logic [7:0] interrupt_latched,
    output logic [7:0] irr_clear,
    output logic [7:0] end_interrupt,
    output logic [2:0] priority_rotate,
    output logic [7:0] vector,
    output logic       vector_valid
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_ACK2 = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       inta_prev;
    logic       inta_fall;
    logic [2:0] hold_level;
    logic [2:0] hold_level_d;
    logic       hold_spurious;
    logic       hold_spurious_d;

    logic [7:0] candidate;
    logic [2:0] scan_lvl;
    logic       win_found;
    logic [2:0] win_level;
    logic [2:0] win_pos;
    logic       isr_found;
    logic [2:0] isr_level;
    logic [2:0] isr_pos;
    logic       winner_valid;

    logic       int_out_d;
    logic       latch_isr_d;
    logic [7:0] interrupt_latched_d;
    logic [7:0] irr_clear_d;
    logic [7:0] vector_d;
    logic       vector_valid_d;
    logic [7:0] aeoi_clear;
    logic [7:0] ocw_clear;
    logic [7:0] end_interrupt_d;
    logic [2:0] priority_rotate_d;

    logic       ocw2_r;
    logic       ocw2_sl;
    logic       ocw2_eoi;
    logic [2:0] ocw2_level;
    logic       ocw2_fmt_ok;

    function automatic logic [7:0] onehot(input logic [2:0] lvl);
        onehot = 8'b1 << lvl;
    endfunction

    assign candidate  = interrupt_request & ~interrupt_mask;
    assign inta_fall  = inta_prev & ~inta_n;

    assign ocw2_r      = ocw2_data[7];
    assign ocw2_sl     = ocw2_data[6];
    assign ocw2_eoi    = ocw2_data[5];
    assign ocw2_level  = ocw2_data[2:0];
    // D4:D3 = 00 identifies an OCW2 word; anything else is not ours to decode.
    assign ocw2_fmt_ok = (ocw2_data[4:3] == 2'b00);

    // Scan both the candidate set and the ISR from the current highest-priority
    // level; pos is the rank (0 = highest) used for the strict-outrank compare.
    always_comb begin
        scan_lvl  = 3'd0;
        win_found = 1'b0;
        win_level = 3'd0;
        win_pos   = 3'd0;
        isr_found = 1'b0;
        isr_level = 3'd0;
        isr_pos   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            scan_lvl = 3'(priority_rotate + 3'd1 + 3'(i));
            if (!win_found && candidate[scan_lvl]) begin
                win_found = 1'b1;
                win_level = scan_lvl;
                win_pos   = 3'(i);
            end
            if (!isr_found && isr[scan_lvl]) begin
                isr_found = 1'b1;
                isr_level = scan_lvl;
                isr_pos   = 3'(i);
            end
        end
    end

    assign winner_valid = win_found && (!isr_found || (win_pos < isr_pos));

    always_comb begin
        state_next          = state;
        hold_level_d        = hold_level;
        hold_spurious_d     = hold_spurious;
        latch_isr_d         = 1'b0;
        interrupt_latched_d = 8'h00;
        irr_clear_d         = 8'h00;
        vector_d            = vector;
        vector_valid_d      = 1'b0;
        aeoi_clear          = 8'h00;
        case (state)
            IDLE: begin
                if (inta_fall) begin
                    state_next = WAIT_ACK2;
                    if (winner_valid) begin
                        latch_isr_d         = 1'b1;
                        interrupt_latched_d = onehot(win_level);
                        irr_clear_d         = onehot(win_level);
                        hold_level_d        = win_level;
                        hold_spurious_d     = 1'b0;
                    end else begin
                        hold_level_d        = SPURIOUS_LEVEL;
                        hold_spurious_d     = 1'b1;
                    end
                end
            end
            WAIT_ACK2: begin
                if (inta_fall) begin
                    state_next     = IDLE;
                    vector_d       = {vector_base, hold_level};
                    vector_valid_d = 1'b1;
                    if (auto_eoi && !hold_spurious) begin
                        aeoi_clear = onehot(hold_level);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // INT is suppressed for the whole acknowledge, including the entry cycle.
        int_out_d = winner_valid && (state_next == IDLE);
    end

    always_comb begin
        ocw_clear         = 8'h00;
        priority_rotate_d = priority_rotate;
        if (ocw2_write && ocw2_fmt_ok) begin
            case ({ocw2_r, ocw2_sl, ocw2_eoi})
                3'b001: begin
                    if (isr_found) ocw_clear = onehot(isr_level);
                end
                3'b011: ocw_clear = onehot(ocw2_level);
                3'b101: begin
                    if (isr_found) begin
                        ocw_clear         = onehot(isr_level);
                        priority_rotate_d = isr_level;
                    end
                end
                3'b111: begin
                    ocw_clear         = onehot(ocw2_level);
                    priority_rotate_d = ocw2_level;
                end
                3'b110: priority_rotate_d = ocw2_level;
                default: ;
            endcase
        end
        end_interrupt_d = ocw_clear | aeoi_clear;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state             <= IDLE;
            inta_prev         <= 1'b1;
            hold_level        <= 3'd0;
            hold_spurious     <= 1'b0;
            priority_rotate   <= 3'b111;
            int_out           <= 1'b0;
            latch_isr         <= 1'b0;
            interrupt_latched <= 8'h00;
            irr_clear         <= 8'h00;
            end_interrupt     <= 8'h00;
            vector            <= 8'h00;
            vector_valid      <= 1'b0;
        end else begin
            state             <= state_next;
            inta_prev         <= inta_n;
            hold_level        <= hold_level_d;
            hold_spurious     <= hold_spurious_d;
            priority_rotate   <= priority_rotate_d;
            int_out           <= int_out_d;
            latch_isr         <= latch_isr_d;
            interrupt_latched <= interrupt_latched_d;
            irr_clear         <= irr_clear_d;
            end_interrupt     <= end_interrupt_d;
            vector            <= vector_d;
            vector_valid      <= vector_valid_d;
        end
    end

endmodule
